// File: rtl/disp_pkg.sv
// Shared definitions for the BCD display encoder and the seven-segment driver:
// FSM encoding, conversion constants and packed-word field positions.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_t;

    localparam logic [3:0] SIGN_POS  = 4'h0;
    localparam logic [3:0] SIGN_NEG  = 4'h1;
    localparam logic [9:0] MAG_MAX   = 10'd999;
    localparam logic [3:0] SHIFT_CNT = 4'd10;

    // Nibble LSB positions inside the packed display word.
    localparam int SIGN_LSB  = 12;
    localparam int DEC_LSB   = 8;
    localparam int UNIT_LSB  = 4;
    localparam int TENTH_LSB = 0;

    // A zero result is always shown positive.
    function automatic logic [15:0] pack_word(input logic neg, input logic [11:0] bcd);
        logic [15:0] w;
        w = '0;
        w[SIGN_LSB  +: 4] = (neg && (bcd != 12'h000)) ? SIGN_NEG : SIGN_POS;
        w[DEC_LSB   +: 4] = bcd[11:8];
        w[UNIT_LSB  +: 4] = bcd[7:4];
        w[TENTH_LSB +: 4] = bcd[3:0];
        return w;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;
endmodule

// File: rtl/disp_bcd_encoder.sv
// Signed tenths-of-unit value to packed sign/decade/unit/tenth display word,
// via magnitude, clamp to 999 and a 10-step serial double-dabble.
module disp_bcd_encoder
    import disp_pkg::*;
#(
    parameter int IN_W = 12
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [IN_W-1:0] din,
    output logic            busy,
    output logic            done,
    output logic [15:0]     data,
    output logic            ovf
);

    disp_state_t     state;
    logic [IN_W-1:0] din_q;
    logic            neg;
    logic            ovf_next;
    logic [9:0]      mag;
    logic [11:0]     acc;
    logic [11:0]     adj;
    logic [3:0]      cnt;

    // One extra bit so the most negative input still has a representable magnitude.
    logic [IN_W:0] din_x;
    logic [IN_W:0] abs_v;
    logic [IN_W:0] max_x;
    logic          clip;
    logic [9:0]    mag_ld;

    assign din_x  = {din_q[IN_W-1], din_q};
    assign abs_v  = din_q[IN_W-1] ? (~din_x + {{IN_W{1'b0}}, 1'b1}) : din_x;
    assign max_x  = {{(IN_W-9){1'b0}}, MAG_MAX};
    assign clip   = (abs_v > max_x);
    assign mag_ld = clip ? MAG_MAX : abs_v[9:0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (acc[4*gi +: 4]),
                .dout (adj[4*gi +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            din_q    <= '0;
            neg      <= 1'b0;
            ovf_next <= 1'b0;
            mag      <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data     <= 16'h0000;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        din_q <= din;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    neg      <= din_q[IN_W-1];
                    mag      <= mag_ld;
                    ovf_next <= clip;
                    acc      <= '0;
                    cnt      <= SHIFT_CNT - 4'd1;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    acc <= {adj[10:0], mag[9]};
                    mag <= {mag[8:0], 1'b0};
                    if (cnt == 4'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Whole word lands in one edge; a new request may be accepted alongside.
                    data <= pack_word(neg, acc);
                    ovf  <= ovf_next;
                    if (start) begin
                        din_q <= din;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_bcd_encoder.sv
// Bench for disp_bcd_encoder: fixed vector table, random values against an
// arithmetic reference, and hand-written handshake/reset sequences.
module tb_disp_bcd_encoder;

    localparam int IN_W = 12;

    logic            clk;
    logic            rstn;
    logic            start;
    logic [IN_W-1:0] din;
    logic            busy;
    logic            done;
    logic [15:0]     data;
    logic            ovf;

    int total;
    int bad;

    disp_bcd_encoder #(.IN_W(IN_W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .data  (data),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          val;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the integer value.
    task automatic model(input int v, output logic [15:0] w, output logic o);
        int m;
        m = (v < 0) ? -v : v;
        o = (m > 999);
        if (m > 999) m = 999;
        w = 16'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
        if (v < 0 && m != 0) w = w + 16'h1000;
    endtask

    task automatic kick(input int v);
        logic [31:0] vb;
        vb = v;
        @(negedge clk);
        din   = vb[IN_W-1:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        bit got;
        lat = 0;
        bc  = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) got = 1;
            else if (busy) bc++;
        end
    endtask

    task automatic conv(input string nm, input int v, input logic [15:0] ew, input logic eo);
        int lat, bc;
        kick(v);
        wait_done(lat, bc);
        chk({nm, " latency"}, lat, 12);
        chk({nm, " busy_cycles"}, bc, 11);
        @(negedge clk);
        chk({nm, " done_one_cycle"}, done, 1'b0);
        chk({nm, " data"}, data, ew);
        chk({nm, " ovf"}, ovf, eo);
    endtask

    initial begin
        vec_t        vecs[11];
        logic [15:0] mw;
        logic        mo;
        int          lat, bc, np, spacing_bad, extra;

        total = 0;
        bad   = 0;
        vecs[0]  = '{123,   16'h0123, 1'b0};
        vecs[1]  = '{-45,   16'h1045, 1'b0};
        vecs[2]  = '{0,     16'h0000, 1'b0};
        vecs[3]  = '{1500,  16'h0999, 1'b1};
        vecs[4]  = '{-2048, 16'h1999, 1'b1};
        vecs[5]  = '{999,   16'h0999, 1'b0};
        vecs[6]  = '{-999,  16'h1999, 1'b0};
        vecs[7]  = '{1000,  16'h0999, 1'b1};
        vecs[8]  = '{-1,    16'h1001, 1'b0};
        vecs[9]  = '{2047,  16'h0999, 1'b1};
        vecs[10] = '{5,     16'h0005, 1'b0};

        rstn  = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset data", data, 16'h0000);
        chk("reset ovf", ovf, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) conv($sformatf("vec%0d", i), vecs[i].val, vecs[i].exp_data, vecs[i].exp_ovf);

        for (int i = 0; i < 30; i++) begin
            int r, s;
            r = $urandom_range(0, 4095);
            s = (r >= 2048) ? r - 4096 : r;
            model(s, mw, mo);
            conv($sformatf("rand%0d(%0d)", i, s), s, mw, mo);
        end

        // Start held high: one done every 12 cycles, nothing missed or doubled.
        @(negedge clk);
        din   = 12'd7;
        start = 1'b1;
        @(posedge clk);
        np = 0;
        spacing_bad = 0;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            if (done) begin
                np++;
                if (k % 12 != 0) spacing_bad++;
            end
            if (k == 48) start = 1'b0;
        end
        chk("b2b pulse_count", np, 4);
        chk("b2b pulse_spacing", spacing_bad, 0);
        @(negedge clk);
        chk("b2b data", data, 16'h0007);
        chk("b2b idle_after", busy, 1'b0);

        // A start while busy must be ignored.
        kick(123);
        repeat (3) @(negedge clk);
        din   = 12'hE0C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("ignore latency", lat + 4, 12);
        @(negedge clk);
        chk("ignore data", data, 16'h0123);
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        chk("ignore no_second_conv", extra, 0);

        // Abort mid-SHIFT with reset; prior result had ovf set so clearing is visible.
        conv("pre_abort", -1234, 16'h1999, 1'b1);
        kick(-777);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort busy", busy, 1'b0);
        chk("abort data", data, 16'h0000);
        chk("abort ovf", ovf, 1'b0);
        rstn = 1'b1;
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("abort no_done", extra, 0);
        conv("post_abort", -45, 16'h1045, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
